sipo_frame_rx: RTL

//  Parametrised serial-in/parallel-out word deserializer with bit counter and
//  per-frame shift direction. Collects DW serial bits and presents each

---
 rtl/sipo_frame_rx.sv | 81 ++++++++
 1 files changed

// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out word deserializer with bit counter, per-frame shift
// direction and frame abort. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module sipo_frame_rx #(
  parameter int DW = 8,
  parameter int CW = $clog2(DW+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          inp,
  input  logic          dir,
  input  logic          clr,
  output logic [DW-1:0] out,
  output logic          out_vld,
`ifdef SIPO_PARITY_EN
  output logic          par_err,
`endif
  output logic          busy
);

  logic [DW-1:0] sh_r;
  logic [CW-1:0] cnt_r;
  logic          dir_r;
  logic          eff_dir;
  logic [DW-1:0] shifted;

  // The first bit of a frame takes its direction straight from the port.
  always_comb begin
    eff_dir = (cnt_r == '0) ? dir : dir_r;
    shifted = eff_dir ? {sh_r[DW-2:0], inp} : {inp, sh_r[DW-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_r    <= '0;
      cnt_r   <= '0;
      dir_r   <= 1'b0;
      out     <= '0;
      out_vld <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      out_vld <= 1'b0;
      if (clr) begin
        cnt_r <= '0;
        sh_r  <= '0;
      end else if (enb) begin
        if (cnt_r == '0) dir_r <= dir;
`ifdef SIPO_PARITY_EN
        // Parity bit cycle: data is already complete in sh_r.
        if (cnt_r == CW'(DW)) begin
          out     <= sh_r;
          par_err <= ^{sh_r, inp};
          out_vld <= 1'b1;
          cnt_r   <= '0;
          sh_r    <= '0;
        end else begin
          sh_r  <= shifted;
          cnt_r <= cnt_r + CW'(1);
        end
`else
        if (cnt_r == CW'(DW-1)) begin
          out     <= shifted;
          out_vld <= 1'b1;
          cnt_r   <= '0;
          sh_r    <= '0;
        end else begin
          sh_r  <= shifted;
          cnt_r <= cnt_r + CW'(1);
        end
`endif
      end
    end
  end

  assign busy = (cnt_r != '0);

endmodule
